// File: rtl/systolic_mma_tile.sv
// N x N output-stationary systolic matrix-multiply tile: streams A columns and B rows,
// skews them, accumulates C = A*B (+C) per PE, then drains C row by row.
module systolic_mma_tile #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 32,
  parameter int unsigned KW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   acc_clear,
  input  logic                   is_signed,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_vec,
  input  logic [N*DW-1:0]        b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_row,
  output logic [N*AW-1:0]        out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned FW = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d, kcnt_q, kcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [RW-1:0]   row_q, row_d, ld_row;
  logic            sgn_q, sgn_d;
  logic            ov_q, ov_d, done_q, done_d;
  logic [N*AW-1:0] od_q, od_d, row_data;
  logic            beat, clr_acc;

  logic [DW-1:0] a_edge [N];
  logic          av_edge [N];
  logic [DW-1:0] b_edge [N];
  logic          bv_edge [N];

  logic [DW-1:0] a_in [N][N];
  logic          av_in [N][N];
  logic [DW-1:0] b_in [N][N];
  logic          bv_in [N][N];

  // pa_q[i][j]: operand leaving PE(i,j) to the right; pb_q[i][j]: leaving PE(i,j) downward
  logic [DW-1:0] pa_q [N][N-1];
  logic          pav_q [N][N-1];
  logic [DW-1:0] pb_q [N-1][N];
  logic          pbv_q [N-1][N];
  logic [AW-1:0] acc_q [N][N];

  assign beat    = in_valid & in_ready;
  assign clr_acc = (state_q == StIdle) & start & acc_clear;

  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic sgn);
    logic [AW-1:0] ea, eb;
    ea = {{(AW - DW){sgn & a[DW-1]}}, a};
    eb = {{(AW - DW){sgn & b[DW-1]}}, b};
    return ea * eb;
  endfunction

  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[gi]  = a_vec[gi*DW +: DW];
      assign av_edge[gi] = beat;
      assign b_edge[gi]  = b_vec[gi*DW +: DW];
      assign bv_edge[gi] = beat;
    end else begin : g_delay
      logic [DW-1:0] a_sk_q [gi];
      logic          av_sk_q [gi];
      logic [DW-1:0] b_sk_q [gi];
      logic          bv_sk_q [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) begin
            a_sk_q[s]  <= '0;
            av_sk_q[s] <= 1'b0;
            b_sk_q[s]  <= '0;
            bv_sk_q[s] <= 1'b0;
          end
        end else begin
          a_sk_q[0]  <= a_vec[gi*DW +: DW];
          av_sk_q[0] <= beat;
          b_sk_q[0]  <= b_vec[gi*DW +: DW];
          bv_sk_q[0] <= beat;
          for (int s = 1; s < gi; s++) begin
            a_sk_q[s]  <= a_sk_q[s-1];
            av_sk_q[s] <= av_sk_q[s-1];
            b_sk_q[s]  <= b_sk_q[s-1];
            bv_sk_q[s] <= bv_sk_q[s-1];
          end
        end
      end
      assign a_edge[gi]  = a_sk_q[gi-1];
      assign av_edge[gi] = av_sk_q[gi-1];
      assign b_edge[gi]  = b_sk_q[gi-1];
      assign bv_edge[gi] = bv_sk_q[gi-1];
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj]  = a_edge[gi];
        assign av_in[gi][gj] = av_edge[gi];
      end else begin : g_a_pipe
        assign a_in[gi][gj]  = pa_q[gi][gj-1];
        assign av_in[gi][gj] = pav_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj]  = b_edge[gj];
        assign bv_in[gi][gj] = bv_edge[gj];
      end else begin : g_b_pipe
        assign b_in[gi][gj]  = pb_q[gi-1][gj];
        assign bv_in[gi][gj] = pbv_q[gi-1][gj];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
          if (j < N - 1) begin
            pa_q[i][j]  <= '0;
            pav_q[i][j] <= 1'b0;
          end
          if (i < N - 1) begin
            pb_q[i][j]  <= '0;
            pbv_q[i][j] <= 1'b0;
          end
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (j < N - 1) begin
            pa_q[i][j]  <= a_in[i][j];
            pav_q[i][j] <= av_in[i][j];
          end
          if (i < N - 1) begin
            pb_q[i][j]  <= b_in[i][j];
            pbv_q[i][j] <= bv_in[i][j];
          end
          if (clr_acc) begin
            acc_q[i][j] <= '0;
          end else if (av_in[i][j] && bv_in[i][j]) begin
            acc_q[i][j] <= acc_q[i][j] + mac_prod(a_in[i][j], b_in[i][j], sgn_q);
          end
        end
      end
    end
  end

  // Row to load into the output register: row 0 on entering DRAIN, else the next row.
  always_comb begin
    ld_row = '0;
    if (state_q == StDrain && row_q != RW'(N - 1)) begin
      ld_row = row_q + RW'(1);
    end
    row_data = '0;
    for (int j = 0; j < N; j++) begin
      row_data[j*AW +: AW] = acc_q[ld_row][j];
    end
  end

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    kcnt_d  = kcnt_q;
    fcnt_d  = fcnt_q;
    row_d   = row_q;
    sgn_d   = sgn_q;
    ov_d    = ov_q;
    od_d    = od_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          klen_d  = k_len;
          sgn_d   = is_signed;
          kcnt_d  = '0;
          fcnt_d  = '0;
          state_d = (k_len == '0) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        if (beat) begin
          kcnt_d = kcnt_q + KW'(1);
          if (kcnt_q == klen_q - KW'(1)) begin
            state_d = StFlush;
            fcnt_d  = '0;
          end
        end
      end
      StFlush: begin
        if (fcnt_q == FW'(2 * N - 2)) begin
          state_d = StDrain;
          row_d   = '0;
          ov_d    = 1'b1;
          od_d    = row_data;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
            ov_d    = 1'b0;
            od_d    = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
            od_d  = row_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      klen_q  <= '0;
      kcnt_q  <= '0;
      fcnt_q  <= '0;
      row_q   <= '0;
      sgn_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      kcnt_q  <= kcnt_d;
      fcnt_q  <= fcnt_d;
      row_q   <= row_d;
      sgn_q   <= sgn_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign out_valid = ov_q;
  assign out_row   = row_q;
  assign out_data  = od_q;
  assign done      = done_q;

endmodule
